// File: rtl/chaotic_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the chaotic Lorenz generator.
package chaotic_pkg;

  localparam int unsigned WIDE_W  = 128;
  localparam int unsigned RHO_INT = 28;

  // beta ~= 2 + 2^-1 + 2^-3 + 2^-5 + 2^-7
  localparam int unsigned BETA_SHIFTS [4] = '{1, 3, 5, 7};

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_A  = 3'd1,
    MUL_B  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic wide_t rho_q(input int unsigned frac_bits);
    return wide_t'(RHO_INT) <<< frac_bits;
  endfunction

  // Clamp to the range of a signed w-bit word; caller truncates to w bits.
  function automatic wide_t sat_signed(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Offset-binary mapping; caller truncates to w bits, which supplies the wrap.
  function automatic wide_t map_phase(input wide_t s, input int unsigned w,
                                      input int unsigned sh);
    return (s <<< sh) ^ (wide_t'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/lorenz_step_dp.sv
// Combinational forward-Euler Lorenz update from old state and registered products.
module lorenz_step_dp
  import chaotic_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DT_SHIFT    = 8
) (
  input  logic signed [PHASE_WIDTH-1:0] x_i,
  input  logic signed [PHASE_WIDTH-1:0] y_i,
  input  logic signed [PHASE_WIDTH-1:0] z_i,
  input  logic signed [PHASE_WIDTH-1:0] pa_i,
  input  logic signed [PHASE_WIDTH-1:0] pb_i,
  output logic signed [PHASE_WIDTH-1:0] x_o,
  output logic signed [PHASE_WIDTH-1:0] y_o,
  output logic signed [PHASE_WIDTH-1:0] z_o
);

  localparam int unsigned IW = PHASE_WIDTH + 8;

  logic signed [IW-1:0] xe, ye, ze, pae, pbe;
  logic signed [IW-1:0] dyx, dx, dy, dz, bz;

  always_comb begin
    xe  = IW'(x_i);
    ye  = IW'(y_i);
    ze  = IW'(z_i);
    pae = IW'(pa_i);
    pbe = IW'(pb_i);

    dyx = ye - xe;
    dx  = (dyx <<< 3) + (dyx <<< 1);
    dy  = pae - ye;
    bz  = ze <<< 1;
    for (int unsigned i = 0; i < $size(BETA_SHIFTS); i++) begin
      bz = bz + (ze >>> BETA_SHIFTS[i]);
    end
    dz  = pbe - bz;

    x_o = PHASE_WIDTH'(sat_signed(wide_t'(xe + (dx >>> DT_SHIFT)), PHASE_WIDTH));
    y_o = PHASE_WIDTH'(sat_signed(wide_t'(ye + (dy >>> DT_SHIFT)), PHASE_WIDTH));
    z_o = PHASE_WIDTH'(sat_signed(wide_t'(ze + (dz >>> DT_SHIFT)), PHASE_WIDTH));
  end

endmodule

// File: rtl/chaotic_lorenz_gen.sv
// Fixed-point discrete Lorenz generator: each ctrl pulse runs ITERS_PER_CTRL Euler
// steps through one shared multiplier, then strobes the offset-binary mapped state.
module chaotic_lorenz_gen
  import chaotic_pkg::*;
#(
  parameter int unsigned            PHASE_WIDTH    = 32,
  parameter int unsigned            FRAC_BITS      = 24,
  parameter int unsigned            DT_SHIFT       = 8,
  parameter int unsigned            ITERS_PER_CTRL = 1,
  parameter int unsigned            OUT_SHIFT      = 2,
  parameter logic [PHASE_WIDTH-1:0] INIT_X         = 32'h0100_0000,
  parameter logic [PHASE_WIDTH-1:0] INIT_Y         = 32'h0100_0000,
  parameter logic [PHASE_WIDTH-1:0] INIT_Z         = 32'h0100_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chaotic_ctrl,
  input  logic                   seed_load,
  input  logic [PHASE_WIDTH-1:0] seed_x,
  input  logic [PHASE_WIDTH-1:0] seed_y,
  input  logic [PHASE_WIDTH-1:0] seed_z,
  output logic                   chaotic_valid,
  output logic [PHASE_WIDTH-1:0] chaotic_x,
  output logic [PHASE_WIDTH-1:0] chaotic_y,
  output logic [PHASE_WIDTH-1:0] chaotic_z,
  output logic                   busy,
  output logic                   ctrl_overrun
);

  localparam int unsigned PW2 = 2 * PHASE_WIDTH;

  state_t state_q, state_d;

  logic signed [PHASE_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [PHASE_WIDTH-1:0] pa_q, pa_d, pb_q, pb_d;
  logic signed [PHASE_WIDTH-1:0] nx, ny, nz;
  logic signed [PHASE_WIDTH-1:0] rz_sat, mul_b, prod_sat;
  logic signed [PW2-1:0]         prod;
  logic [PHASE_WIDTH-1:0]        ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [8:0]                    cnt_inc;
  logic                          valid_q, valid_d, ovr_q, ovr_d;

  // Single multiplier: x*(RHO-z) in MUL_A, x*y in MUL_B.
  always_comb begin
    rz_sat   = PHASE_WIDTH'(sat_signed(rho_q(FRAC_BITS) - wide_t'(z_q), PHASE_WIDTH));
    mul_b    = (state_q == MUL_B) ? y_q : rz_sat;
    prod     = PW2'(x_q) * PW2'(mul_b);
    prod_sat = PHASE_WIDTH'(sat_signed(wide_t'(prod >>> FRAC_BITS), PHASE_WIDTH));
  end

  lorenz_step_dp #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .DT_SHIFT    (DT_SHIFT)
  ) u_step (
    .x_i  (x_q),
    .y_i  (y_q),
    .z_i  (z_q),
    .pa_i (pa_q),
    .pb_i (pb_q),
    .x_o  (nx),
    .y_o  (ny),
    .z_o  (nz)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oz_d    = oz_q;
    cnt_d   = cnt_q;
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    valid_d = 1'b0;
    ovr_d   = chaotic_ctrl && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // Seed and ctrl together: the iteration starts from the freshly loaded seed.
        if (seed_load) begin
          x_d = $signed(seed_x);
          y_d = $signed(seed_y);
          z_d = $signed(seed_z);
        end
        if (chaotic_ctrl) state_d = MUL_A;
      end
      MUL_A: begin
        pa_d    = prod_sat;
        state_d = MUL_B;
      end
      MUL_B: begin
        pb_d    = prod_sat;
        state_d = UPDATE;
      end
      UPDATE: begin
        x_d     = nx;
        y_d     = ny;
        z_d     = nz;
        cnt_d   = cnt_inc[7:0];
        state_d = (cnt_inc < 9'(ITERS_PER_CTRL)) ? MUL_A : DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        ox_d    = PHASE_WIDTH'(map_phase(wide_t'(x_q), PHASE_WIDTH, OUT_SHIFT));
        oy_d    = PHASE_WIDTH'(map_phase(wide_t'(y_q), PHASE_WIDTH, OUT_SHIFT));
        oz_d    = PHASE_WIDTH'(map_phase(wide_t'(z_q), PHASE_WIDTH, OUT_SHIFT));
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= INIT_X;
      y_q     <= INIT_Y;
      z_q     <= INIT_Z;
      pa_q    <= '0;
      pb_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oz_q    <= oz_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign chaotic_valid = valid_q;
  assign chaotic_x     = ox_q;
  assign chaotic_y     = oy_q;
  assign chaotic_z     = oz_q;
  assign busy          = (state_q != IDLE);
  assign ctrl_overrun  = ovr_q;

endmodule

// File: tb/tb_chaotic_lorenz_gen.sv
// Bench for chaotic_lorenz_gen: two instances (1 and 3 steps per ctrl) checked every
// cycle against a transaction-level Lorenz model, plus hand-computed literal results.
module tb_chaotic_lorenz_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl      [2];
  logic        seed_load [2];
  logic [31:0] sx [2], sy [2], sz [2];
  logic        valid_o [2], busy_o [2], ovr_o [2];
  logic [31:0] x_o [2], y_o [2], z_o [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int vcnt [2] = '{0, 0};
  int ocnt [2] = '{0, 0};

  always #5 clk = ~clk;

  chaotic_lorenz_gen #(.ITERS_PER_CTRL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .chaotic_ctrl(ctrl[0]), .seed_load(seed_load[0]),
    .seed_x(sx[0]), .seed_y(sy[0]), .seed_z(sz[0]), .chaotic_valid(valid_o[0]),
    .chaotic_x(x_o[0]), .chaotic_y(y_o[0]), .chaotic_z(z_o[0]),
    .busy(busy_o[0]), .ctrl_overrun(ovr_o[0]));

  chaotic_lorenz_gen #(.ITERS_PER_CTRL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .chaotic_ctrl(ctrl[1]), .seed_load(seed_load[1]),
    .seed_x(sx[1]), .seed_y(sy[1]), .seed_z(sz[1]), .chaotic_valid(valid_o[1]),
    .chaotic_x(x_o[1]), .chaotic_y(y_o[1]), .chaotic_z(z_o[1]),
    .busy(busy_o[1]), .ctrl_overrun(ovr_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam longint RHO  = 28 * 64'sd16777216;
  localparam longint INIT = 64'sd16777216;

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic void lstep(input longint x, input longint y, input longint z,
                                output longint xo, output longint yo, output longint zo);
    longint pa, pb, dx, dy, dz;
    pa = sat32((x * sat32(RHO - z)) >>> 24);
    pb = sat32((x * y) >>> 24);
    dx = 10 * (y - x);
    dy = pa - y;
    dz = pb - (2 * z + (z >>> 1) + (z >>> 3) + (z >>> 5) + (z >>> 7));
    xo = sat32(x + (dx >>> 8));
    yo = sat32(y + (dy >>> 8));
    zo = sat32(z + (dz >>> 8));
  endfunction

  function automatic logic [31:0] mapo(input longint s);
    logic [31:0] t;
    t = 32'(s << 2);
    return t ^ 32'h8000_0000;
  endfunction

  function automatic int iters(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  longint      mx [2], my [2], mz [2], px [2], py [2], pz [2];
  longint      ax, ay, az, bx, by, bz;
  int          rem [2];
  bit          ev [2], eo [2];
  logic [31:0] ex [2], ey [2], ez [2];

  // A ctrl accepted while idle completes 3N+1 edges later with N model steps.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mx[i] = INIT; my[i] = INIT; mz[i] = INIT;
        rem[i] = 0; ev[i] = 1'b0; eo[i] = 1'b0;
        ex[i] = '0; ey[i] = '0; ez[i] = '0;
      end else begin
        ev[i] = 1'b0;
        eo[i] = 1'b0;
        if (rem[i] == 0) begin
          if (seed_load[i]) begin
            mx[i] = longint'($signed(sx[i]));
            my[i] = longint'($signed(sy[i]));
            mz[i] = longint'($signed(sz[i]));
          end
          if (ctrl[i]) begin
            ax = mx[i]; ay = my[i]; az = mz[i];
            for (int k = 0; k < iters(i); k++) begin
              lstep(ax, ay, az, bx, by, bz);
              ax = bx; ay = by; az = bz;
            end
            px[i] = ax; py[i] = ay; pz[i] = az;
            rem[i] = 3 * iters(i) + 1;
          end
        end else begin
          if (ctrl[i]) eo[i] = 1'b1;
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            mx[i] = px[i]; my[i] = py[i]; mz[i] = pz[i];
            ev[i] = 1'b1;
            ex[i] = mapo(px[i]); ey[i] = mapo(py[i]); ez[i] = mapo(pz[i]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (valid_o[i] === 1'b1) vcnt[i]++;
        if (ovr_o[i] === 1'b1) ocnt[i]++;
        chk($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(ev[i]));
        chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(rem[i] != 0));
        chk($sformatf("overrun%0d", i), 32'(ovr_o[i]), 32'(eo[i]));
        chk($sformatf("x%0d", i), x_o[i], ex[i]);
        chk($sformatf("y%0d", i), y_o[i], ey[i]);
        chk($sformatf("z%0d", i), z_o[i], ez[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_ctrl(input int i, output int lat);
    ctrl[i] = 1'b1;
    tick(1);
    ctrl[i]      = 1'b0;
    seed_load[i] = 1'b0;
    lat = 0;
    while (valid_o[i] !== 1'b1 && lat < 60) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic chk_s1(input string tag);
    chk({tag, "_x"}, x_o[0], 32'h8400_0000);
    chk({tag, "_y"}, y_o[0], 32'h8468_0000);
    chk({tag, "_z"}, z_o[0], 32'h83F9_5800);
  endtask

  int lat, v0, o0;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ctrl[i] = 1'b0; seed_load[i] = 1'b0; sx[i] = '0; sy[i] = '0; sz[i] = '0;
    end
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_valid", 32'(valid_o[0]), 32'd0);
    chk("rst_x", x_o[0], 32'd0);
    rst_n = 1'b1;
    tick(2);

    run_ctrl(0, lat);
    chk("lat_n1", 32'(lat), 32'd4);
    chk_s1("s1");

    tick(2);
    run_ctrl(1, lat);
    chk("lat_n3", 32'(lat), 32'd10);

    tick(2);
    v0 = vcnt[0]; o0 = ocnt[0];
    ctrl[0] = 1'b1; tick(1);
    ctrl[0] = 1'b0; tick(1);
    ctrl[0] = 1'b1; tick(1);
    ctrl[0] = 1'b0; tick(8);
    chk("ovr_valids", 32'(vcnt[0] - v0), 32'd1);
    chk("ovr_pulses", 32'(ocnt[0] - o0), 32'd1);

    seed_load[0] = 1'b1; sx[0] = '0; sy[0] = '0; sz[0] = '0;
    run_ctrl(0, lat);
    chk("zero_lat", 32'(lat), 32'd4);
    chk("zero_x", x_o[0], 32'h8000_0000);
    chk("zero_y", y_o[0], 32'h8000_0000);
    chk("zero_z", z_o[0], 32'h8000_0000);

    tick(2);
    seed_load[0] = 1'b1; sx[0] = 32'h7F00_0000; sy[0] = 32'h7F00_0000; sz[0] = '0;
    run_ctrl(0, lat);
    chk("sat_x", x_o[0], 32'h7C00_0000);
    chk("sat_y", y_o[0], 32'h7C03_FFFC);
    chk("sat_z", z_o[0], 32'h81FF_FFFC);

    tick(2);
    v0 = vcnt[0];
    ctrl[0] = 1'b1; tick(1);
    ctrl[0] = 1'b0; tick(2);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_x", x_o[0], 32'd0);
    tick(8);
    chk("abort_novalid", 32'(vcnt[0] - v0), 32'd0);
    run_ctrl(0, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk_s1("post_rst");

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        ctrl[i]      = ($urandom_range(0, 5) == 0);
        seed_load[i] = ($urandom_range(0, 7) == 0);
        sx[i] = $urandom;
        sy[i] = $urandom;
        sz[i] = $urandom;
      end
      tick(1);
    end
    for (int i = 0; i < 2; i++) begin
      ctrl[i] = 1'b0; seed_load[i] = 1'b0;
    end
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
